counter_mod_updown: RTL

- Parametrised successor to the team's fixed 8-bit free-running incrementer/register counter.
- Adds:
  - configurable width;
  - programmable modulus (count range 0 to MOD_MAX);
  - up/down direction;
  - synchronous clear, synchronous load and count enable;
  - wrap or saturate mode;
  - terminal-count and wrap-event flags.
- Used as a general sequencing/timing counter inside control blocks (baud dividers, frame counters, timeouts).

---
 rtl/counter_mod_updown_if.sv | 28 ++
 rtl/counter_mod_updown.sv | 71 +++++++
 2 files changed

// File: rtl/counter_mod_updown_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_mod_updown_if : control/status bundle for the counter      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface counter_mod_updown_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output clear, load, load_val, en, up,
    input  count, tc, wrap
  );

  modport slave (
    input  clear, load, load_val, en, up,
    output count, tc, wrap
  );
endinterface
`default_nettype wire

// File: rtl/counter_mod_updown.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_mod_updown : modulo up/down counter, wrap or saturate      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module counter_mod_updown #(
  parameter int          WIDTH     = 8,
  parameter int unsigned MOD_MAX   = 255,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  wire logic            clk,
  input  wire logic            reset,
  counter_mod_updown_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;
  logic             wrap_reg;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    at_max       = (count_reg == MAX_VAL);
    at_zero      = (count_reg == '0);
    load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
  end

  // Boundary detection is by compare, so a full-range modulus wraps exactly
  // where natural WIDTH-bit overflow would.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= RST_VAL;
      wrap_reg  <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      if (bus.clear) begin
        count_reg <= '0;
      end else if (bus.load) begin
        count_reg <= load_clamped;
      end else if (bus.en) begin
        if (bus.up) begin
          if (!at_max) begin
            count_reg <= count_reg + ONE;
          end else if (!SATURATE) begin
            count_reg <= '0;
            wrap_reg  <= 1'b1;
          end
        end else begin
          if (!at_zero) begin
            count_reg <= count_reg - ONE;
          end else if (!SATURATE) begin
            count_reg <= MAX_VAL;
            wrap_reg  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.count = count_reg;
  assign bus.wrap  = wrap_reg;
  assign bus.tc    = bus.en & ~bus.clear & ~bus.load &
                     ((bus.up & at_max) | (~bus.up & at_zero));

endmodule
`default_nettype wire
